frame_buffer_scheduler: RTL and testbench
=========================================

Name: frame_buffer_scheduler

Overview:
- Owns the single port of the synchronous pixel RAM. Splits that RAM into two frame banks and shares the port between two clients:
  - the LED matrix controller, which reads the front bank;
  - a pixel writer (loader/host), which fills the back bank.
- Display reads always win the port. Writes use idle cycles.
- Bank swaps are deferred until the next frame boundary so a scan never tears.
- Sits between `led_matrix_controller` and `single_port_ram_sync` in the 5 MHz domain.

Parameters:
- BANK_ADDR_WIDTH, 11, address bits per bank. RAM address width = BANK_ADDR_WIDTH+1.
- DATA_WIDTH, 24, pixel word width (RGB888).

Ports:
- i_clk  input  1  5 MHz pixel clock.
- rst_n  input  1  asynchronous, active-low reset.
- i_disp_rd_en  input  1  controller reads this cycle.
- i_disp_addr  input  BANK_ADDR_WIDTH  controller pixel address within the bank.
- i_frame_start  input  1  one-cycle pulse at the start of a frame scan.
- o_disp_data  output  DATA_WIDTH  read data; equals i_ram_dout.
- i_wr_valid  input  1  writer has a pixel.
- i_wr_addr  input  BANK_ADDR_WIDTH  writer address within the back bank.
- i_wr_data  input  DATA_WIDTH  writer pixel.
- o_wr_ready  output  1  write accepted this cycle if i_wr_valid.
- i_swap_req  input  1  request to present the back bank.
- o_swap_busy  output  1  swap pending or clear in progress.
- o_front_bank  output  1  bank currently displayed.
- o_ram_we  output  1  RAM write enable.
- o_ram_addr  output  BANK_ADDR_WIDTH+1  {bank, addr}.
- o_ram_din  output  DATA_WIDTH  RAM write data.
- i_ram_dout  input  DATA_WIDTH  RAM read data (1-cycle latency).

Behaviour:
- **Reset:** state S_RUN; o_front_bank=0; o_swap_busy=0; o_wr_ready=0; o_ram_we=0; clear counter=0.
  - Reset mid-swap or mid-clear abandons it. Back-bank contents are undefined after such a reset.
- **States:** S_RUN, S_SWAP_WAIT, S_CLEAR (S_CLEAR exists only with the optional feature).
- **Port mux (combinational):**
  - If i_disp_rd_en: o_ram_addr={o_front_bank,i_disp_addr}, o_ram_we=0.
  - Else if a write is accepted: o_ram_addr={~o_front_bank,i_wr_addr}, o_ram_we=1, o_ram_din=i_wr_data.
  - Else: o_ram_addr holds the display address, o_ram_we=0.
- **Read latency:** o_disp_data is valid 1 cycle after i_disp_rd_en, a pass-through of i_ram_dout. There is no extra register.
- **Writer readiness:** o_wr_ready = (state==S_RUN) && !i_disp_rd_en. It is combinational on i_disp_rd_en.
  - A write handshake is valid && ready in the same cycle.
  - Writer data must be held until accepted.
- **S_RUN:**
  - i_swap_req=1 moves to S_SWAP_WAIT and sets o_swap_busy.
  - A write accepted in the same cycle as i_swap_req still completes.
- **S_SWAP_WAIT:**
  - o_wr_ready=0.
  - On i_frame_start=1, toggle o_front_bank at that edge. Go to S_CLEAR if the feature is enabled, else S_RUN with o_swap_busy=0.
  - The new bank applies to reads from the cycle after i_frame_start. The controller must not read during the i_frame_start cycle.
- **i_swap_req outside S_RUN:** ignored; not queued.
- **i_frame_start in S_RUN:** no effect.
- **Wrap:** addresses never cross a bank; the bank bit comes only from o_front_bank.

Optional Feature:
- Macro: FB_CLEAR_ON_SWAP_EN.
- **With the macro:** after each swap, S_CLEAR walks a counter from 0 to 2^BANK_ADDR_WIDTH-1 over the new back bank, writing zeros.
  - It writes only on cycles with !i_disp_rd_en; the counter advances only on those writes.
  - o_wr_ready=0 and o_swap_busy=1 throughout.
  - After the final address is written, return to S_RUN and drop o_swap_busy.
- **Without the macro:** S_CLEAR is absent, and the back bank keeps the old frame (a delta update is possible).

Decomposition:
- Shared package `led_matrix_pkg` holds:
  - state encoding localparams (S_RUN=2'd0, S_SWAP_WAIT=2'd1, S_CLEAR=2'd2);
  - default widths, shared with `led_matrix_controller`.
- No sub-module. The clear counter and mux are inline.

Test Plan:
- Reset released, i_disp_rd_en=1 with i_disp_addr=5 -> o_ram_addr=12'h005, o_ram_we=0; o_disp_data=RAM[5] one cycle later.
- i_wr_valid=1 with addr 3, data 24'hFF0000, while i_disp_rd_en toggles 1,0 -> ready 0 then 1; exactly one write, to 12'h803, on the second cycle.
- i_swap_req pulse, then writes attempted, then i_frame_start after 10 cycles -> o_wr_ready=0 for those 10 cycles; o_front_bank goes 0->1 the cycle after i_frame_start; the next read address is 12'h800|addr.
- Second i_swap_req while in S_SWAP_WAIT -> ignored; exactly one toggle.
- rst_n asserted mid-S_SWAP_WAIT -> all outputs go to reset values immediately (async); o_front_bank=0.
- FB_CLEAR_ON_SWAP_EN defined, with reads in every odd cycle -> 2048 zero writes to bank 0 after the swap; o_swap_busy falls one cycle after the write to 12'h7FF.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED matrix pixel path: default widths and
// the frame buffer scheduler state encoding.
package led_matrix_pkg;

  localparam int unsigned LM_BANK_ADDR_WIDTH = 11;
  localparam int unsigned LM_DATA_WIDTH      = 24;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_SWAP_WAIT = 2'd1,
    S_CLEAR     = 2'd2
  } fb_state_t;

endpackage

// File: rtl/frame_buffer_scheduler.sv
// Frame buffer scheduler: shares one synchronous RAM port between display
// reads (front bank, always win) and pixel writes (back bank, idle cycles).
// Bank swaps wait for the next frame start so a scan never tears.
// Optional macro FB_CLEAR_ON_SWAP_EN: zero the new back bank after each swap.
module frame_buffer_scheduler
  import led_matrix_pkg::*;
#(
  parameter int unsigned BANK_ADDR_WIDTH = LM_BANK_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = LM_DATA_WIDTH
) (
  input  logic                       i_clk,
  input  logic                       rst_n,
  input  logic                       i_disp_rd_en,
  input  logic [BANK_ADDR_WIDTH-1:0] i_disp_addr,
  input  logic                       i_frame_start,
  output logic [DATA_WIDTH-1:0]      o_disp_data,
  input  logic                       i_wr_valid,
  input  logic [BANK_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]      i_wr_data,
  output logic                       o_wr_ready,
  input  logic                       i_swap_req,
  output logic                       o_swap_busy,
  output logic                       o_front_bank,
  output logic                       o_ram_we,
  output logic [BANK_ADDR_WIDTH:0]   o_ram_addr,
  output logic [DATA_WIDTH-1:0]      o_ram_din,
  input  logic [DATA_WIDTH-1:0]      i_ram_dout
);

  fb_state_t r_state;
  fb_state_t w_state_nxt;
  logic      r_front_bank;
  logic      w_front_bank_nxt;
  logic      r_swap_busy;
  logic      w_swap_busy_nxt;
  logic      w_wr_ready;
  logic      w_wr_fire;
`ifdef FB_CLEAR_ON_SWAP_EN
  logic [BANK_ADDR_WIDTH-1:0] r_clr_cnt;
  logic [BANK_ADDR_WIDTH-1:0] w_clr_cnt_nxt;
`endif

  // Writer may only use idle cycles in S_RUN; held low while in reset.
  assign w_wr_ready = rst_n && (r_state == S_RUN) && !i_disp_rd_en;
  assign w_wr_fire  = w_wr_ready && i_wr_valid;

  assign o_wr_ready   = w_wr_ready;
  assign o_swap_busy  = r_swap_busy;
  assign o_front_bank = r_front_bank;
  assign o_disp_data  = i_ram_dout;

  // State, bank select and busy flag registers.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RUN;
      r_front_bank <= 1'b0;
      r_swap_busy  <= 1'b0;
`ifdef FB_CLEAR_ON_SWAP_EN
      r_clr_cnt    <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_front_bank <= w_front_bank_nxt;
      r_swap_busy  <= w_swap_busy_nxt;
`ifdef FB_CLEAR_ON_SWAP_EN
      r_clr_cnt    <= w_clr_cnt_nxt;
`endif
    end
  end

  // Next-state logic: swap request, deferred toggle, optional bank clear.
  always_comb begin
    w_state_nxt      = r_state;
    w_front_bank_nxt = r_front_bank;
    w_swap_busy_nxt  = r_swap_busy;
`ifdef FB_CLEAR_ON_SWAP_EN
    w_clr_cnt_nxt    = r_clr_cnt;
`endif
    case (r_state)
      S_RUN: begin
        if (i_swap_req) begin
          w_state_nxt     = S_SWAP_WAIT;
          w_swap_busy_nxt = 1'b1;
        end
      end
      S_SWAP_WAIT: begin
        if (i_frame_start) begin
          w_front_bank_nxt = ~r_front_bank;
`ifdef FB_CLEAR_ON_SWAP_EN
          w_state_nxt      = S_CLEAR;
          w_clr_cnt_nxt    = '0;
`else
          w_state_nxt      = S_RUN;
          w_swap_busy_nxt  = 1'b0;
`endif
        end
      end
`ifdef FB_CLEAR_ON_SWAP_EN
      S_CLEAR: begin
        // Counter only advances on cycles where the zero write actually lands.
        if (!i_disp_rd_en) begin
          w_clr_cnt_nxt = r_clr_cnt + BANK_ADDR_WIDTH'(1);
          if (r_clr_cnt == {BANK_ADDR_WIDTH{1'b1}}) begin
            w_state_nxt     = S_RUN;
            w_swap_busy_nxt = 1'b0;
          end
        end
      end
`endif
      default: begin
        w_state_nxt     = S_RUN;
        w_swap_busy_nxt = 1'b0;
      end
    endcase
  end

  // RAM port mux: display read, else writer, else (optional) clear, else idle.
  always_comb begin
    o_ram_addr = {r_front_bank, i_disp_addr};
    o_ram_we   = 1'b0;
    o_ram_din  = i_wr_data;
    if (!i_disp_rd_en) begin
      if (w_wr_fire) begin
        o_ram_addr = {~r_front_bank, i_wr_addr};
        o_ram_we   = 1'b1;
      end
`ifdef FB_CLEAR_ON_SWAP_EN
      else if (r_state == S_CLEAR) begin
        o_ram_addr = {~r_front_bank, r_clr_cnt};
        o_ram_we   = 1'b1;
        o_ram_din  = '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench for frame_buffer_scheduler with a behavioural 1-cycle RAM.
`timescale 1ns/1ps
module tb_frame_buffer_scheduler;

  localparam int unsigned BAW = 11;
  localparam int unsigned DW  = 24;
  localparam int unsigned RAW = BAW + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           disp_rd_en;
  logic [BAW-1:0] disp_addr;
  logic           frame_start;
  logic [DW-1:0]  disp_data;
  logic           wr_valid;
  logic [BAW-1:0] wr_addr;
  logic [DW-1:0]  wr_data;
  logic           wr_ready;
  logic           swap_req;
  logic           swap_busy;
  logic           front_bank;
  logic           ram_we;
  logic [RAW-1:0] ram_addr;
  logic [DW-1:0]  ram_din;
  logic [DW-1:0]  ram_dout;

  logic [DW-1:0]  mem [0:(1<<RAW)-1];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_count = 0;
  int zero_b0_count = 0;
  int cyc_7ff = -1;
  int base_wr;
  int base_zero;
  logic [RAW-1:0] last_wr_addr = '0;

  frame_buffer_scheduler #(.BANK_ADDR_WIDTH(BAW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .rst_n(rst_n),
    .i_disp_rd_en(disp_rd_en), .i_disp_addr(disp_addr), .i_frame_start(frame_start),
    .o_disp_data(disp_data),
    .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
    .i_swap_req(swap_req), .o_swap_busy(swap_busy), .o_front_bank(front_bank),
    .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_din(ram_din), .i_ram_dout(ram_dout)
  );

  always #100 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= ram_addr;
      if (!ram_addr[RAW-1] && ram_din == '0) zero_b0_count <= zero_b0_count + 1;
      if (ram_addr == 12'h7FF) cyc_7ff <= cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << RAW); i++) mem[i] = DW'(i) ^ 24'hA50000;
    mem[5] = 24'h5A5A5A;
    rst_n = 1'b0; disp_rd_en = 1'b0; disp_addr = '0; frame_start = 1'b0;
    wr_valid = 1'b1; wr_addr = 11'd1; wr_data = 24'h111111; swap_req = 1'b0;

    #50;
    check("rst_front", 32'(front_bank), 32'h0);
    check("rst_busy", 32'(swap_busy), 32'h0);
    check("rst_ready", 32'(wr_ready), 32'h0);
    check("rst_we", 32'(ram_we), 32'h0);

    // Display read of address 5
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; wr_valid = 1'b0; disp_rd_en = 1'b1; disp_addr = 11'd5;
    #1;
    check("rd_addr", 32'(ram_addr), 32'h005);
    check("rd_we", 32'(ram_we), 32'h0);
    check("rd_ready", 32'(wr_ready), 32'h0);
    @(posedge clk); #1;
    check("rd_data", 32'(disp_data), 32'h5A5A5A);

    // Write blocked by read, then accepted into back bank 1
    @(negedge clk);
    base_wr = wr_count;
    wr_valid = 1'b1; wr_addr = 11'd3; wr_data = 24'hFF0000;
    #1;
    check("wr_blk_ready", 32'(wr_ready), 32'h0);
    check("wr_blk_we", 32'(ram_we), 32'h0);
    @(negedge clk);
    disp_rd_en = 1'b0;
    #1;
    check("wr_ready", 32'(wr_ready), 32'h1);
    check("wr_we", 32'(ram_we), 32'h1);
    check("wr_addr", 32'(ram_addr), 32'h803);
    check("wr_din", 32'(ram_din), 32'hFF0000);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    check("wr_once", 32'(wr_count - base_wr), 32'h1);
    check("wr_last_addr", 32'(last_wr_addr), 32'h803);
    check("wr_mem", 32'(mem[12'h803]), 32'hFF0000);

    // Swap request; writes stall for 10 cycles; second request ignored
    @(negedge clk);
    swap_req = 1'b1;
    #1;
    check("swap_busy_pre", 32'(swap_busy), 32'h0);
    @(posedge clk); #1;
    swap_req = 1'b0;
    check("swap_busy", 32'(swap_busy), 32'h1);
    check("swap_front_hold", 32'(front_bank), 32'h0);
    base_wr = wr_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wr_valid = 1'b1; wr_addr = 11'd7; wr_data = 24'h123456; disp_rd_en = 1'b0;
      swap_req = (i == 4);
      #1;
      check("wait_ready", 32'(wr_ready), 32'h0);
      check("wait_we", 32'(ram_we), 32'h0);
    end
    @(negedge clk);
    swap_req = 1'b0; frame_start = 1'b1;
    #1;
    check("fs_ready", 32'(wr_ready), 32'h0);
    check("fs_front_old", 32'(front_bank), 32'h0);
    check("wait_no_writes", 32'(wr_count - base_wr), 32'h0);
    @(posedge clk); #1;
    check("fs_front_new", 32'(front_bank), 32'h1);

`ifdef FB_CLEAR_ON_SWAP_EN
    check("clr_busy", 32'(swap_busy), 32'h1);
    base_zero = zero_b0_count;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      frame_start = 1'b0; disp_rd_en = i[0]; disp_addr = 11'd9;
      #1;
      if (i == 0) check("clr_ready", 32'(wr_ready), 32'h0);
      @(posedge clk); #1;
      if (!swap_busy) break;
    end
    check("clr_done", 32'(swap_busy), 32'h0);
    check("clr_count", 32'(zero_b0_count - base_zero), 32'd2048);
    check("clr_busy_fall", 32'(cyc - cyc_7ff), 32'h0);
    check("clr_mem5", 32'(mem[5]), 32'h0);
    check("clr_mem7ff", 32'(mem[12'h7FF]), 32'h0);
`else
    check("swap_done", 32'(swap_busy), 32'h0);
`endif

    // Read now from bank 1, pending write lands in bank 0
    @(negedge clk);
    frame_start = 1'b0; disp_rd_en = 1'b1; disp_addr = 11'd9;
    #1;
    check("new_rd_addr", 32'(ram_addr), 32'h809);
    check("new_rd_ready", 32'(wr_ready), 32'h0);
    @(negedge clk);
    disp_rd_en = 1'b0;
    #1;
    check("new_wr_ready", 32'(wr_ready), 32'h1);
    check("new_wr_addr", 32'(ram_addr), 32'h007);
    check("new_wr_din", 32'(ram_din), 32'h123456);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    check("new_wr_mem", 32'(mem[7]), 32'h123456);

    // Frame start while running has no effect; ignored request left nothing pending
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    check("run_fs_front", 32'(front_bank), 32'h1);
    check("run_fs_busy", 32'(swap_busy), 32'h0);

    // Async reset in the middle of a swap wait
    @(negedge clk);
    swap_req = 1'b1;
    @(posedge clk); #1;
    swap_req = 1'b0;
    check("rst2_busy_pre", 32'(swap_busy), 32'h1);
    #30;
    wr_valid = 1'b1; disp_rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst2_front", 32'(front_bank), 32'h0);
    check("rst2_busy", 32'(swap_busy), 32'h0);
    check("rst2_ready", 32'(wr_ready), 32'h0);
    check("rst2_we", 32'(ram_we), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; wr_valid = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
